// File: rtl/qos_aging_policy_engine.sv
// rtl/qos_aging_policy_engine.sv - per-channel QoS level with wait-time aging and token-bucket throttling
module qos_aging_policy_engine #(
  parameter int NUM_CH        = 4,
  parameter int LVL_W         = 3,
  parameter int AGE_THRESH    = 8,
  parameter int TOKEN_MAX     = 4,
  parameter int REFILL_PERIOD = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    qos_enable_i,
  input  logic [NUM_CH-1:0]       req_valid_i,
  input  logic [NUM_CH-1:0]       req_ready_i,
  input  logic [NUM_CH-1:0]       critical_i,
  input  logic [NUM_CH*LVL_W-1:0] base_level_i,
  output logic [NUM_CH*LVL_W-1:0] level_o,
  output logic [NUM_CH-1:0]       urgent_o,
  output logic [NUM_CH-1:0]       throttle_o
);

  localparam int AGE_W = $clog2(AGE_THRESH);
  localparam int TOK_W = $clog2(TOKEN_MAX + 1);
  localparam int CNT_W = $clog2(REFILL_PERIOD);

  localparam logic [LVL_W-1:0] LVL_MAX  = '1;
  localparam logic [LVL_W-1:0] LVL_TOP  = LVL_MAX - LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_THRESH - 1);
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);
  localparam logic [TOK_W-1:0] TOK_FULL = TOK_W'(TOKEN_MAX);
  localparam logic [TOK_W-1:0] TOK_ONE  = TOK_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFILL_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] refill_cnt_q;
  logic [CNT_W-1:0] refill_cnt_d;
  logic             tick;

  logic [AGE_W-1:0] age_q [NUM_CH];
  logic [AGE_W-1:0] age_d [NUM_CH];
  logic [LVL_W-1:0] esc_q [NUM_CH];
  logic [LVL_W-1:0] esc_d [NUM_CH];
  logic [TOK_W-1:0] tok_q [NUM_CH];
  logic [TOK_W-1:0] tok_d [NUM_CH];
  logic [LVL_W-1:0] base_clip [NUM_CH];
  logic [LVL_W:0]   lvl_sum [NUM_CH];
  logic [NUM_CH-1:0] hs;
  logic [NUM_CH-1:0] waiting;
  logic [NUM_CH-1:0] consume;

  logic [NUM_CH*LVL_W-1:0] level_d;
  logic [NUM_CH-1:0]       urgent_d;
  logic [NUM_CH-1:0]       throttle_d;

  assign hs      = req_valid_i & req_ready_i;
  assign waiting = req_valid_i & ~req_ready_i;
  assign consume = hs & ~critical_i;

  always_comb begin
    tick         = (refill_cnt_q == CNT_LAST);
    refill_cnt_d = tick ? '0 : refill_cnt_q + CNT_ONE;
    level_d      = '0;
    urgent_d     = '0;
    throttle_d   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      age_d[c]     = age_q[c];
      esc_d[c]     = esc_q[c];
      tok_d[c]     = tok_q[c];
      base_clip[c] = base_level_i[c*LVL_W +: LVL_W];
      if (base_clip[c] == LVL_MAX) base_clip[c] = LVL_TOP;

      // An exhausted, non-critical channel stops aging so it cannot buy priority by waiting.
      if (!waiting[c]) begin
        age_d[c] = '0;
        esc_d[c] = '0;
      end else if (tok_q[c] == '0 && !critical_i[c]) begin
        age_d[c] = age_q[c];
      end else if (age_q[c] == AGE_LAST) begin
        age_d[c] = '0;
        if (esc_q[c] != LVL_TOP) esc_d[c] = esc_q[c] + LVL_ONE;
      end else begin
        age_d[c] = age_q[c] + AGE_ONE;
      end

      if (tick && !consume[c]) begin
        if (tok_q[c] != TOK_FULL) tok_d[c] = tok_q[c] + TOK_ONE;
      end else if (!tick && consume[c]) begin
        if (tok_q[c] != '0) tok_d[c] = tok_q[c] - TOK_ONE;
      end

      lvl_sum[c] = {1'b0, base_clip[c]} + {1'b0, esc_d[c]};
      if (critical_i[c] && req_valid_i[c]) begin
        level_d[c*LVL_W +: LVL_W] = LVL_MAX;
        urgent_d[c]               = 1'b1;
      end else if (tok_d[c] == '0 || !req_valid_i[c]) begin
        level_d[c*LVL_W +: LVL_W] = base_clip[c];
      end else if (lvl_sum[c] > {1'b0, LVL_TOP}) begin
        level_d[c*LVL_W +: LVL_W] = LVL_TOP;
      end else begin
        level_d[c*LVL_W +: LVL_W] = lvl_sum[c][LVL_W-1:0];
      end
      throttle_d[c] = (tok_d[c] == '0) && !critical_i[c];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || !qos_enable_i) begin
      refill_cnt_q <= '0;
      level_o      <= '0;
      urgent_o     <= '0;
      throttle_o   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        age_q[c] <= '0;
        esc_q[c] <= '0;
        tok_q[c] <= TOK_FULL;
      end
    end else begin
      refill_cnt_q <= refill_cnt_d;
      level_o      <= level_d;
      urgent_o     <= urgent_d;
      throttle_o   <= throttle_d;
      for (int c = 0; c < NUM_CH; c++) begin
        age_q[c] <= age_d[c];
        esc_q[c] <= esc_d[c];
        tok_q[c] <= tok_d[c];
      end
    end
  end

endmodule
